// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative IEEE-754 single-precision square root (Newton-Raphson on 1/sqrt).
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   x         - single-precision operand, captured when in_valid && in_ready
//   in_valid  - x is valid
//   in_ready  - block is idle and can take an operand
//   y         - single-precision sqrt(x), held while out_valid
//   out_valid - y is valid
//   out_ready - consumer takes y
// Datapath is Q2.30 unsigned with one shared 32x32 multiplier. Latency from the
// accept cycle to the out_valid cycle is 3*ITERS+4 for every operand.
module fsqrt_iter #(
   parameter int ITERS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
);
   typedef enum logic [2:0] {IDLE, SEED, ITER, FINAL, DONE} state_t;

   // 6-bit seeds of round(64*2/sqrt(v))-64, v taken at the centre of each
   // mantissa segment. Index bit 6 = e[0]: 1 -> v in [1,2), 0 -> v in [2,4).
   function automatic logic [767:0] build_tab();
      logic [767:0] tab;
      logic [63:0]  q, r, c;
      int           val;
      tab = '0;
      for (int i = 0; i < 128; i++) begin
         q = (64'd1 << 37) / (64'(i[6] ? 1 : 2) * 64'(129 + 2 * (i % 64)));
         r = '0;
         for (int b = 15; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= q) r = c;
         end
         val = int'((r + 64'd128) >> 8);
         tab[i*6 +: 6] = 6'(val > 127 ? 63 : val < 64 ? 0 : val - 64);
      end
      return tab;
   endfunction

   localparam logic [767:0] SEED_TAB = build_tab();

   state_t       state_q, state_d;
   logic [1:0]   phase_q, phase_d, pass_q, pass_d, spec_q, spec_d;
   logic [31:0]  x_q, x_d, m_q, m_d, wy_q, wy_d, t_q, t_d, r_q, r_d, y_q, y_d;
   logic [7:0]   ex_q, ex_d;
   logic [31:0]  three_t, mul_a, mul_b, rounded;
   logic [63:0]  prod;
   logic [29:0]  nr;
   logic [6:0]   sidx;
   logic [5:0]   seed;
   logic [1:0]   spec;
   logic signed [9:0] ue;
   logic         hi, inc;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign y         = y_q;

   always_comb begin
      sidx    = {x_q[23], x_q[22:17]};
      seed    = SEED_TAB[10'(sidx) * 10'd6 +: 6];
      ue      = $signed({2'b00, x_q[30:23]}) - 10'sd127;
      // special-case code: 0 normal, 1 signed zero, 2 +inf, 3 NaN
      spec    = (x_q[30:23] == 8'h00) ? 2'd1 :
                (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0) ? 2'd3 :
                x_q[31] ? 2'd3 :
                (x_q[30:23] == 8'hFF) ? 2'd2 : 2'd0;
      three_t = (t_q > 32'hC000_0000) ? 32'd0 : 32'hC000_0000 - t_q;
      mul_a   = (state_q == FINAL || phase_q == 2'd1) ? m_q : wy_q;
      mul_b   = (state_q == FINAL || phase_q == 2'd0) ? wy_q :
                (phase_q == 2'd1) ? t_q : three_t;
      prod    = 64'(mul_a) * 64'(mul_b);
      // r is just below 2; a result just under 1 needs one extra left shift
      hi      = r_q >= 32'h4000_0000;
      nr      = hi ? r_q[29:0] : {r_q[28:0], 1'b0};
      inc     = nr[6] & ((|nr[5:0]) | nr[7]);
      // mantissa carry ripples straight into the exponent field
      rounded = {1'b0, ex_q - {7'd0, ~hi}, nr[29:7]} + 32'(inc);
      state_d = state_q;
      phase_d = phase_q;
      pass_d  = pass_q;
      spec_d  = spec_q;
      x_d     = x_q;
      m_d     = m_q;
      wy_d    = wy_q;
      t_d     = t_q;
      r_d     = r_q;
      y_d     = y_q;
      ex_d    = ex_q;
      case (state_q)
         IDLE: if (in_valid) begin
            x_d     = x;
            state_d = SEED;
         end
         SEED: begin
            // odd unbiased exponent (e[0]==0) pre-shifts m into [2,4)
            m_d     = x_q[23] ? {2'b01, x_q[22:0], 7'd0} : {1'b1, x_q[22:0], 8'd0};
            // seed table holds 2/sqrt(v), so its leading 1 sits at weight 1/2
            wy_d    = {3'b001, seed, 23'd0};
            ex_d    = 8'((ue >>> 1) + 10'sd127);
            spec_d  = spec;
            phase_d = 2'd0;
            pass_d  = 2'd0;
            state_d = ITER;
         end
         ITER: begin
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            if (phase_q != 2'd2) t_d = 32'(prod >> 30);
            else begin
               wy_d = 32'(prod >> 31);
               if (pass_q == 2'(ITERS - 1)) state_d = FINAL;
               else pass_d = pass_q + 2'd1;
            end
         end
         FINAL: begin
            if (phase_q == 2'd0) begin
               r_d     = 32'(prod >> 30);
               phase_d = 2'd1;
            end else begin
               y_d     = (spec_q == 2'd0) ? rounded :
                         (spec_q == 2'd1) ? {x_q[31], 31'd0} :
                         (spec_q == 2'd2) ? 32'h7F80_0000 : 32'h7FC0_0000;
               phase_d = 2'd0;
               pass_d  = 2'd0;
               state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         pass_q  <= '0;
         spec_q  <= '0;
         x_q     <= '0;
         m_q     <= '0;
         wy_q    <= '0;
         t_q     <= '0;
         r_q     <= '0;
         y_q     <= '0;
         ex_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pass_q  <= pass_d;
         spec_q  <= spec_d;
         x_q     <= x_d;
         m_q     <= m_d;
         wy_q    <= wy_d;
         t_q     <= t_d;
         r_q     <= r_d;
         y_q     <= y_d;
         ex_q    <= ex_d;
      end
   end
endmodule

// File: tb/tb_fsqrt_iter.sv
// tb_fsqrt_iter: directed and random checks of fsqrt_iter against an exact integer sqrt model.
module tb_fsqrt_iter;
   localparam int ITERS = 2;
   localparam int LAT   = 3 * ITERS + 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] x = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int checks = 0;
   int passes = 0;

   fsqrt_iter #(.ITERS(ITERS)) dut (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned r = 0, c;
      for (int b = 26; b >= 0; b--) begin
         c = r | (64'd1 << b);
         if (c * c <= v) r = c;
      end
      return r;
   endfunction

   // correctly rounded single-precision sqrt, special cases included
   function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
      int e, ue, k;
      longint unsigned n, v, q;
      logic [23:0] sig;
      logic rinc;
      e = int'(a[30:23]);
      if (e == 0) return {a[31], 31'd0};
      if (e == 255 && a[22:0] != 0) return 32'h7FC0_0000;
      if (a[31]) return 32'h7FC0_0000;
      if (e == 255) return 32'h7F80_0000;
      ue = e - 127;
      n  = {40'd1, a[22:0]};
      if (ue % 2 != 0) begin
         n = n * 2;
         k = (ue - 1) / 2;
      end else k = ue / 2;
      v    = n << 25;
      q    = isqrt(v);
      sig  = 24'(q >> 1);
      rinc = q[0] && (q * q != v || sig[0]);
      return {1'b0, 8'(k + 127), sig[22:0]} + 32'(rinc);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
      logic [31:0] d;
      d = (obs > exp) ? obs - exp : exp - obs;
      checks++;
      assert (d <= 32'(tol)) passes++;
      else $error("FAIL %s: observed %h expected %h (tol %0d)", tag, obs, exp, tol);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   // returns y and the cycle count from the accept cycle to the first out_valid cycle
   task automatic op(input logic [31:0] xv, output logic [31:0] yv, output int lat);
      wait_ready();
      x = xv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      x = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      yv = y;
      if (out_ready) @(negedge clk);
   endtask

   logic [31:0] yv, yh, xv;
   logic [31:0] spec_in [5]  = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h7FC0_0001};
   logic [31:0] spec_out [5] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
   int lat, cnt;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0, 0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
      chk("rst_y", y, 32'd0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1, 0);

      op(32'h4080_0000, yv, lat);
      chk("sqrt4", yv, 32'h4000_0000, 1);
      chk("sqrt4_lat", 32'(lat), 32'(LAT), 0);
      op(32'h4000_0000, yv, lat);
      chk("sqrt2", yv, 32'h3FB5_04F3, 1);
      chk("sqrt2_lat", 32'(lat), 32'(LAT), 0);

      for (int i = 0; i < 5; i++) begin
         op(spec_in[i], yv, lat);
         chk($sformatf("special_%h", spec_in[i]), yv, spec_out[i], 0);
         chk("special_lat", 32'(lat), 32'(LAT), 0);
      end

      // back-pressure: result must hold and busy-time in_valid must be ignored
      out_ready = 1'b0;
      op(32'h4180_0000, yh, lat);
      chk("hold_first", yh, 32'h4080_0000, 1);
      chk("hold_lat", 32'(lat), 32'(LAT), 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x = $urandom;
         @(negedge clk);
         chk("hold_y", y, yh, 0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1, 0);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0, 0);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1, 0);
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("no_extra_result", 32'(cnt), 32'd0, 0);

      // reset in the middle of ITER abandons the operation
      wait_ready();
      x = 32'h4040_0000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0, 0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0, 0);
      chk("midrst_y", y, 32'd0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rel_in_ready", {31'd0, in_ready}, 32'd1, 0);
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("midrst_no_output", 32'(cnt), 32'd0, 0);
      op(32'h4110_0000, yv, lat);
      chk("sqrt9", yv, 32'h4040_0000, 1);
      chk("sqrt9_lat", 32'(lat), 32'(LAT), 0);

      for (int i = 0; i < 2000; i++) begin
         xv = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
         if (i < 4) xv[22:0] = (i % 2 == 0) ? 23'd0 : 23'h7FFFFF;
         op(xv, yv, lat);
         chk($sformatf("rand_%h", xv), yv, ref_sqrt(xv), 1);
         chk("rand_lat", 32'(lat), 32'(LAT), 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
